// File: rtl/pu_riscv_mmio_master_ahb3.sv
// AHB3-Lite single-transfer MMIO initiator with a two-slot address/data pipeline.
// Optional PU_RISCV_MMIO_ALIGN_CHECK_EN rejects misaligned or oversized requests locally.
module pu_riscv_mmio_master_ahb3 #(
    parameter int         HDATA_SIZE    = 32,
    parameter int         HADDR_SIZE    = 32,
    parameter logic [3:0] HPROT_DEFAULT = 4'b0011
) (
    input  logic                  HCLK,
    input  logic                  HRESET,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [HADDR_SIZE-1:0] req_addr,
    input  logic                  req_write,
    input  logic [2:0]            req_size,
    input  logic [HDATA_SIZE-1:0] req_wdata,

    output logic                  rsp_valid,
    output logic [HDATA_SIZE-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic [1:0]            HTRANS,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HMASTLOCK,
    output logic [HDATA_SIZE-1:0] HWDATA,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic                  ap_valid;
    logic [HADDR_SIZE-1:0] ap_addr;
    logic                  ap_write;
    logic [2:0]            ap_size;
    logic [HDATA_SIZE-1:0] ap_wdata;
    logic                  ap_bad;

    logic                  dp_valid;
    logic                  dp_write;
    logic [HDATA_SIZE-1:0] dp_wdata;
    logic                  dp_bad;

    logic                  err2;

    logic                  err1;
    logic                  accept;
    logic                  move;
    logic                  emit;
    logic                  req_bad;

`ifdef PU_RISCV_MMIO_ALIGN_CHECK_EN
    localparam int MAX_SIZE = $clog2(HDATA_SIZE / 8);

    logic [HADDR_SIZE-1:0] align_mask;

    assign align_mask = ~({HADDR_SIZE{1'b1}} << req_size);
    assign req_bad    = (int'(req_size) > MAX_SIZE)
                      || (|(req_addr & align_mask));
`else
    assign req_bad = 1'b0;
`endif

    // first ERROR cycle freezes everything; HREADY=1 implies we are past it
    assign err1   = HRESP && !HREADY;
    assign move   = HREADY && ap_valid && !err2;
    assign emit   = HREADY && dp_valid;

    assign req_ready = (!ap_valid || (HREADY && !err2)) && !err1;
    assign accept    = req_valid && req_ready;

    assign HTRANS    = (ap_valid && !err2 && !ap_bad) ? HTRANS_NONSEQ
                                                      : HTRANS_IDLE;
    assign HADDR     = ap_addr;
    assign HWRITE    = ap_write;
    assign HSIZE     = ap_size;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_DEFAULT;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = dp_wdata;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ap_valid <= 1'b0;
            ap_addr  <= '0;
            ap_write <= 1'b0;
            ap_size  <= 3'b000;
            ap_wdata <= '0;
            ap_bad   <= 1'b0;
        end else if (accept) begin
            ap_valid <= 1'b1;
            ap_addr  <= req_addr;
            ap_write <= req_write;
            ap_size  <= req_size;
            ap_wdata <= req_wdata;
            ap_bad   <= req_bad;
        end else if (move) begin
            ap_valid <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_wdata <= '0;
            dp_bad   <= 1'b0;
        end else if (HREADY) begin
            dp_valid <= move;
            if (move) begin
                dp_write <= ap_write;
                dp_wdata <= ap_wdata;
                dp_bad   <= ap_bad;
            end
        end
    end

    // err2 marks the second ERROR cycle, where the pending address is withdrawn
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            err2 <= 1'b0;
        end else if (err1) begin
            err2 <= 1'b1;
        end else if (HREADY) begin
            err2 <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= emit;
            rsp_err   <= emit && (HRESP || dp_bad);
            rsp_rdata <= (emit && !dp_write && !dp_bad) ? HRDATA : '0;
        end
    end

endmodule

// File: tb/tb_pu_riscv_mmio_master_ahb3.sv
// Scoreboard bench: memory-level reference model, AHB slave model with random waits/errors.
// Honours PU_RISCV_MMIO_ALIGN_CHECK_EN for the alignment expectations.
module tb_pu_riscv_mmio_master_ahb3;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [2:0]  req_size = 3'd2;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    pu_riscv_mmio_master_ahb3 dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .HTRANS    (HTRANS),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HMASTLOCK (HMASTLOCK),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] slv_mem[logic [31:0]];

    int n_vec = 0;
    int n_err = 0;

    int rand_waits = 0;
    int force_wait = 0;

    // values seen by the slave, sampled mid-cycle
    logic        s_rst = 1'b1;
    logic        s_hready = 1'b1;
    logic        s_hresp = 1'b0;
    logic        s_nonseq = 1'b0;
    logic [31:0] s_addr = '0;
    logic        s_write = 1'b0;
    logic [31:0] s_hwdata = '0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit err_region(input logic [31:0] a);
        return a[31] & a[7];
    endfunction

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        return slv_mem.exists(w) ? slv_mem[w] : init_val(w);
    endfunction

    // what the request should return, judged by memory semantics alone
    function automatic void model_push(input logic [31:0] a, input logic w,
                                       input logic [31:0] d,
                                       input logic [2:0] sz);
        exp_t e;
        bit   bad;
        logic [31:0] m;
        m   = (32'd1 << sz) - 32'd1;
        bad = 1'b0;
`ifdef PU_RISCV_MMIO_ALIGN_CHECK_EN
        bad = (sz > 3'd2) || ((a & m) != 0);
`endif
        if (bad) begin
            e.err = 1'b1;
            e.rdata = '0;
        end else if (err_region(a)) begin
            e.err = 1'b1;
            e.rdata = w ? 32'h0 : ~a;
        end else if (w) begin
            ref_mem[a >> 2] = d;
            e.err = 1'b0;
            e.rdata = '0;
        end else begin
            e.err = 1'b0;
            e.rdata = ref_rd(a);
        end
        exp_q.push_back(e);
    endfunction

    // called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [2:0] sz);
        bit acc;
        acc = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_wdata = d;
        req_size  = sz;
        for (int k = 0; k < 100; k++) begin
            @(negedge HCLK);
            if (req_ready) begin
                acc = 1'b1;
                model_push(a, w, d, sz);
                break;
            end
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: req_ready stuck 0 for addr %0h", a);
            req_valid = 1'b0;
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge HCLK);
        end
        @(posedge HCLK);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (2) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    // monitor: scoreboard pop plus bus protocol checks
    initial begin
        exp_t        e;
        logic        p_wait;
        logic        p_nonseq;
        logic [31:0] p_addr;
        p_wait = 1'b0;
        p_nonseq = 1'b0;
        p_addr = '0;
        forever begin
            @(negedge HCLK);
            s_rst    = HRESET;
            s_hready = HREADY;
            s_hresp  = HRESP;
            s_nonseq = (HTRANS == 2'b10);
            s_addr   = HADDR;
            s_write  = HWRITE;
            s_hwdata = HWDATA;
            if (!HRESET && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got rdata %0h err %0b, none expected",
                             rsp_rdata, rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                end
            end
            if (!HRESET) begin
                check("htrans_legal",
                      64'(HTRANS == 2'b00 || HTRANS == 2'b10), 64'd1);
                if (p_wait && p_nonseq)
                    check("ap_stable_in_wait", {30'd0, HTRANS, HADDR},
                          {30'd0, 2'b10, p_addr});
            end
            p_wait   = !HRESET && !HREADY && !HRESP;
            p_nonseq = (HTRANS == 2'b10);
            p_addr   = HADDR;
        end
    end

    // AHB slave model
    initial begin
        bit          d_act;
        logic [31:0] d_addr;
        bit          d_write;
        bit          d_err;
        bit          d_estage;
        int          d_wait;
        d_act = 0;
        d_addr = '0;
        d_write = 0;
        d_err = 0;
        d_estage = 0;
        d_wait = 0;
        forever begin
            @(posedge HCLK);
            #1;
            if (s_rst) begin
                d_act = 0;
                HREADY = 1'b1;
                HRESP = 1'b0;
                HRDATA = '0;
            end else begin
                if (d_act && s_hready) begin
                    if (d_write && !d_err) slv_mem[d_addr >> 2] = s_hwdata;
                    d_act = 0;
                end
                if (s_hready && s_nonseq) begin
                    d_act = 1;
                    d_addr = s_addr;
                    d_write = s_write;
                    d_err = err_region(s_addr);
                    d_estage = 0;
                    if (force_wait > 0) begin
                        d_wait = force_wait;
                        force_wait = 0;
                    end else if (rand_waits != 0 && $urandom_range(0, 3) == 0) begin
                        d_wait = $urandom_range(1, 3);
                    end else begin
                        d_wait = 0;
                    end
                end
                HRDATA = $urandom;
                if (!d_act) begin
                    HREADY = 1'b1;
                    HRESP = 1'b0;
                end else if (d_wait > 0) begin
                    HREADY = 1'b0;
                    HRESP = 1'b0;
                    d_wait--;
                end else if (d_err) begin
                    HRESP = 1'b1;
                    HRDATA = ~d_addr;
                    HREADY = d_estage;
                    d_estage = 1;
                end else begin
                    HREADY = 1'b1;
                    HRESP = 1'b0;
                    if (!d_write) HRDATA = slv_rd(d_addr);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        bit          w;

        #2;
        check("rst_htrans", 64'(HTRANS), 64'd0);
        check("rst_haddr", 64'(HADDR), 64'd0);
        check("rst_hwrite", 64'(HWRITE), 64'd0);
        check("rst_hsize", 64'(HSIZE), 64'd0);
        check("rst_hwdata", 64'(HWDATA), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        @(posedge HCLK);
        #1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        check("post_rst_ready", 64'(req_ready), 64'd1);
        check("hburst", 64'(HBURST), 64'd0);
        check("hprot", 64'(HPROT), 64'd3);
        check("hmastlock", 64'(HMASTLOCK), 64'd0);
        @(posedge HCLK);
        #1;

        // zero-wait write
        send(32'h8000_1000, 1'b1, 32'h1, 3'd2);
        req_valid = 1'b0;
        @(negedge HCLK);
        check("zw_htrans", 64'(HTRANS), 64'd2);
        check("zw_hwrite", 64'(HWRITE), 64'd1);
        check("zw_haddr", 64'(HADDR), 64'h8000_1000);
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        check("zw_hwdata", 64'(HWDATA), 64'h1);
        check("zw_rsp_early", 64'(rsp_valid), 64'd0);
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        check("zw_rsp_valid", 64'(rsp_valid), 64'd1);
        drain();

        // back-to-back reads
        ref_mem[32'h100 >> 2] = 32'hA5A5_A5A5;
        slv_mem[32'h100 >> 2] = 32'hA5A5_A5A5;
        ref_mem[32'h104 >> 2] = 32'h5A5A_5A5A;
        slv_mem[32'h104 >> 2] = 32'h5A5A_5A5A;
        send(32'h100, 1'b0, 32'h0, 3'd2);
        send(32'h104, 1'b0, 32'h0, 3'd2);
        req_valid = 1'b0;
        @(negedge HCLK);
        check("b2b_htrans2", 64'(HTRANS), 64'd2);
        check("b2b_haddr2", 64'(HADDR), 64'h104);
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        check("b2b_rsp1_valid", 64'(rsp_valid), 64'd1);
        check("b2b_rsp1_data", 64'(rsp_rdata), 64'hA5A5_A5A5);
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        check("b2b_rsp2_valid", 64'(rsp_valid), 64'd1);
        check("b2b_rsp2_data", 64'(rsp_rdata), 64'h5A5A_5A5A);
        drain();

        // wait states on a write with a read queued
        force_wait = 3;
        send(32'h8000_1004, 1'b1, 32'hCAFE_0001, 3'd2);
        send(32'h8000_1008, 1'b0, 32'h0, 3'd2);
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge HCLK);
            check("ws_htrans", 64'(HTRANS), 64'd2);
            check("ws_haddr", 64'(HADDR), 64'h8000_1008);
            check("ws_ready", 64'(req_ready), 64'd0);
            check("ws_no_rsp", 64'(rsp_valid), 64'd0);
            @(posedge HCLK);
            #1;
        end
        drain();

        // ERROR on a write while a read sits in address phase
        send(32'h8000_1080, 1'b1, 32'hDEAD_0000, 3'd2);
        send(32'h200, 1'b0, 32'h0, 3'd2);
        req_valid = 1'b0;
        @(negedge HCLK);
        check("err1_htrans", 64'(HTRANS), 64'd2);
        check("err1_ready", 64'(req_ready), 64'd0);
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        check("err2_htrans", 64'(HTRANS), 64'd0);
        check("err2_ready", 64'(req_ready), 64'd0);
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        check("reissue_htrans", 64'(HTRANS), 64'd2);
        check("reissue_haddr", 64'(HADDR), 64'h200);
        check("err_rsp_valid", 64'(rsp_valid), 64'd1);
        check("err_rsp_err", 64'(rsp_err), 64'd1);
        drain();

        // misaligned word write
        send(32'h102, 1'b1, 32'h7777_0000, 3'd2);
        req_valid = 1'b0;
        @(negedge HCLK);
`ifdef PU_RISCV_MMIO_ALIGN_CHECK_EN
        check("align_idle", 64'(HTRANS), 64'd0);
`else
        check("align_issued", 64'(HTRANS), 64'd2);
        check("align_haddr", 64'(HADDR), 64'h102);
`endif
        @(posedge HCLK);
        #1;
        drain();

        // randomized traffic
        rand_waits = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge HCLK);
                    #1;
                end
            end
            a = ($urandom_range(0, 1) != 0) ? 32'h8000_1000 : 32'h0000_0100;
            a = a | (32'($urandom_range(0, 15)) << 4)
                  | (32'($urandom_range(0, 3)) << 2);
            sz = 3'd2;
`ifdef PU_RISCV_MMIO_ALIGN_CHECK_EN
            if ($urandom_range(0, 7) == 0) a = a | 32'h2;
            if ($urandom_range(0, 15) == 0) sz = 3'd3;
`endif
            w = ($urandom_range(0, 1) != 0);
            send(a, w, $urandom, sz);
        end
        drain();
        rand_waits = 0;

        // reset while a read is in its data phase
        send(32'h300, 1'b0, 32'h0, 3'd2);
        req_valid = 1'b0;
        @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        #1;
        check("mid_rst_htrans", 64'(HTRANS), 64'd0);
        check("mid_rst_rsp", 64'(rsp_valid), 64'd0);
        exp_q.delete();
        @(posedge HCLK);
        #1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge HCLK);
            check("after_rst_ready", 64'(req_ready), 64'd1);
            check("after_rst_htrans", 64'(HTRANS), 64'd0);
            check("after_rst_rsp", 64'(rsp_valid), 64'd0);
        end
        @(posedge HCLK);
        #1;
        send(32'h304, 1'b0, 32'h0, 3'd2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pu_riscv_mmio_master_ahb3.md
Name: pu_riscv_mmio_master_ahb3

Overview:
- AMBA3 AHB-Lite single-transfer bus initiator for the RISC-V simulation bench and debug paths.
- Accepts MMIO read/write requests on a valid/ready port and issues them as pipelined NONSEQ SINGLE transfers.
- Returns one response pulse per request, carrying read data and error status.
- Typical use: driving host-catch and UART-TX addresses on MMIO slave models.

Parameters:
- HDATA_SIZE, 32, data bus width in bits (32 or 64).
- HADDR_SIZE, 32, address bus width in bits.
- HPROT_DEFAULT, 4'b0011, constant HPROT value: data access, privileged, non-bufferable, non-cacheable.

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at the clock edge.
- req_addr  in  HADDR_SIZE  byte address.
- req_write  in  1  1 = write, 0 = read.
- req_size  in  3  HSIZE encoding (0 = byte, 1 = half, 2 = word, 3 = dword).
- req_wdata  in  HDATA_SIZE  write data, already lane-placed by the requester.
- rsp_valid  out  1  one-cycle pulse when a transfer completes.
- rsp_rdata  out  HDATA_SIZE  HRDATA sampled at read completion; 0 for writes.
- rsp_err  out  1  transfer ended with an ERROR response.
- HTRANS  out  2  IDLE (0) or NONSEQ (2) only.
- HADDR  out  HADDR_SIZE  address.
- HWRITE  out  1  direction.
- HSIZE  out  3  transfer size.
- HBURST  out  3  constant SINGLE (0).
- HPROT  out  4  equals HPROT_DEFAULT.
- HMASTLOCK  out  1  constant 0.
- HWDATA  out  HDATA_SIZE  write data for the current data phase.
- HRDATA  in  HDATA_SIZE  read data.
- HREADY  in  1  bus ready.
- HRESP  in  1  0 = OKAY, 1 = ERROR.

Behaviour:

Registers:
- Address-phase slot: ap_valid, addr, write, size, wdata.
- Data-phase slot: dp_valid, write, wdata.
- Flag: err2, set while in the second ERROR cycle.

Reset (HRESET=1, asynchronous):
- All of the following clear immediately: ap_valid, dp_valid, err2.
- Outputs go to: HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- req_ready=1 after reset deasserts.
- Reset mid-transfer drops in-flight requests; no response is ever emitted for them.

Bus outputs and ready:
- HTRANS = NONSEQ iff ap_valid && !err2; otherwise IDLE. HADDR, HWRITE and HSIZE come from the address slot.
- HWDATA comes from the data slot. It holds its last value when dp_valid=0.
- req_ready = (!ap_valid || (HREADY && !err2)) && !(HRESP && !HREADY). This signal is combinational.

Pipeline (edges with HREADY=1 and not in the first ERROR cycle):
- If dp_valid: emit the response. rsp_valid=1 next cycle; rsp_err=HRESP; rsp_rdata=HRDATA for reads, 0 for writes.
- If ap_valid && !err2: the address slot moves into the data slot. Otherwise dp_valid becomes 0.
- An accepted request loads the address slot.
- The address slot is cleared when it has moved and no new request is accepted.

Wait states (HREADY=0, HRESP=0):
- All slots hold; the address phase stays stable.

ERROR response:
- First cycle (HRESP=1, HREADY=0): set err2 at the edge, so HTRANS=IDLE in the second cycle (the pending address phase is cancelled).
- Second cycle (HRESP=1, HREADY=1): the data phase completes with rsp_err=1. The address slot is retained and not moved; err2 clears.
- The cancelled request re-issues as NONSEQ in the following cycle.

Latency and throughput:
- Request accepted at edge N → NONSEQ during cycle N+1.
- With a zero-wait slave, rsp_valid is asserted after edge N+2.
- One request per cycle sustained.

Ordering:
- Responses are returned in request order.
- At most 2 transfers outstanding (one in address phase, one in data phase).

Optional Feature:
- Macro: PU_RISCV_MMIO_ALIGN_CHECK_EN.
- Defined: a request whose req_addr is not aligned to 2^req_size, or whose req_size exceeds log2(HDATA_SIZE/8), is accepted but never issued on the bus.
  - The block emits rsp_valid=1, rsp_err=1, rsp_rdata=0 in the cycle after the request's in-order turn (after all earlier responses).
  - HTRANS stays IDLE for that slot.
- Undefined: no checking; all requests are issued as given.

Test Plan:
- Zero-wait write: write 0x80001000 with wdata 0x1, size 2 → NONSEQ/HWRITE=1 in cycle 1, HWDATA=0x1 in cycle 2, rsp_valid with rsp_err=0 in cycle 3.
- Back-to-back: reads of 0x100 then 0x104 (slave returns 0xA5A5A5A5 then 0x5A5A5A5A) → NONSEQ in consecutive cycles, two consecutive rsp_valid pulses carrying the data in order.
- Wait states: HREADY=0 for 3 cycles during a write data phase with a read queued → HADDR/HTRANS of the read stable for all 3 cycles, req_ready=0, one response after HREADY rises.
- ERROR: slave errors the write to 0x80001080 while a read of 0x200 is in address phase → HTRANS=IDLE in the second error cycle, write response has rsp_err=1, read re-issued next cycle and completes with rsp_err=0.
- Reset mid-op: assert HRESET during a data phase → HTRANS=IDLE immediately, no rsp_valid; a post-reset request completes normally.
- Alignment check (macro defined): write 0x102 with size 2 → no NONSEQ, rsp_valid=1 with rsp_err=1. With the macro undefined, the same request is issued on the bus.
